// File: rtl/controlador_acao_display.sv
// Action sequencer for the autonomous toy plus a 4-digit multiplexed 7-segment scan.
// Each action is held for DUR_TICKS timebase ticks; the display shows action, cycle count, state and a blank digit.
//
// state      | meaning
// OCIOSO     | idle, waiting for iniciar (also entered on obstacle abort)
// EXECUTANDO | running an action, timer advances on each tick
// PAUSADO    | running but frozen while pausar is high
// FIM        | sequence completed, last action code held
module controlador_acao_display #(
    parameter int PRESCALE_DIV = 50000,
    parameter int DUR_TICKS    = 2000,
    parameter int ACAO_MAX     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pausar,
    input  logic       obstaculo,
    output logic [3:0] acao,
    output logic [3:0] valor_digito,
    output logic [3:0] anodo,
    output logic       ocupado,
    output logic       fim,
    output logic       erro
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int TW = (DUR_TICKS > 1) ? $clog2(DUR_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE_DIV - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DUR_TICKS - 1);
    localparam logic [3:0]    ACAO_LAST  = 4'(ACAO_MAX);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        EXECUTANDO = 2'd1,
        PAUSADO    = 2'd2,
        FIM        = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    acao_q, acao_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    ciclos_q, ciclos_d;
    logic [1:0]    scan_q, scan_d;
    logic [3:0]    anodo_q, anodo_d;
    logic          ocupado_q, ocupado_d;
    logic          fim_q, fim_d;
    logic          erro_q, erro_d;
    logic          tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            acao_q    <= 4'd0;
            pre_q     <= '0;
            timer_q   <= '0;
            ciclos_q  <= 4'd0;
            scan_q    <= 2'd0;
            anodo_q   <= 4'b1110;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            acao_q    <= acao_d;
            pre_q     <= pre_d;
            timer_q   <= timer_d;
            ciclos_q  <= ciclos_d;
            scan_q    <= scan_d;
            anodo_q   <= anodo_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
            erro_q    <= erro_d;
        end
    end

    always_comb begin
        tick    = (pre_q == PRE_LAST);
        pre_d   = tick ? '0 : pre_q + PW'(1);
        scan_d  = tick ? scan_q + 2'd1 : scan_q;
        anodo_d = ~(4'b0001 << scan_d);
    end

    always_comb begin
        estado_d = estado_q;
        acao_d   = acao_q;
        timer_d  = timer_q;
        ciclos_d = ciclos_q;
        erro_d   = erro_q;
        fim_d    = 1'b0;
        case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar && !obstaculo) begin
                    estado_d = EXECUTANDO;
                    acao_d   = 4'd1;
                    timer_d  = '0;
                    erro_d   = 1'b0;
                end
            end
            EXECUTANDO: begin
                if (obstaculo) begin
                    estado_d = OCIOSO;
                    acao_d   = 4'd0;
                    timer_d  = '0;
                    erro_d   = 1'b1;
                end else if (pausar) begin
                    estado_d = PAUSADO;
                end else if (tick) begin
                    if (timer_q == TIMER_LAST) begin
                        if (acao_q < ACAO_LAST) begin
                            acao_d  = acao_q + 4'd1;
                            timer_d = '0;
                        end else begin
                            estado_d = FIM;
                            fim_d    = 1'b1;
                            ciclos_d = (ciclos_q == 4'd9) ? 4'd0 : ciclos_q + 4'd1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            PAUSADO: begin
                // Ticks seen while paused are discarded; the timer resumes exactly where it stopped.
                if (obstaculo) begin
                    estado_d = OCIOSO;
                    acao_d   = 4'd0;
                    timer_d  = '0;
                    erro_d   = 1'b1;
                end else if (!pausar) begin
                    estado_d = EXECUTANDO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
        ocupado_d = (estado_d == EXECUTANDO) || (estado_d == PAUSADO);
    end

    always_comb begin
        case (scan_q)
            2'd0:    valor_digito = acao_q;
            2'd1:    valor_digito = ciclos_q;
            2'd2:    valor_digito = {2'b00, estado_q};
            default: valor_digito = 4'hF;
        endcase
    end

    assign acao    = acao_q;
    assign anodo   = anodo_q;
    assign ocupado = ocupado_q;
    assign fim     = fim_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_controlador_acao_display.sv
// Self-checking bench for controlador_acao_display with small timing parameters.
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_controlador_acao_display;

    localparam int P = 4;
    localparam int D = 3;
    localparam int A = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       pausar = 1'b0;
    logic       obstaculo = 1'b0;
    logic [3:0] acao, valor_digito, anodo;
    logic       ocupado, fim, erro;

    int n_cmp = 0;
    int n_err = 0;

    controlador_acao_display #(.PRESCALE_DIV(P), .DUR_TICKS(D), .ACAO_MAX(A)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .pausar(pausar), .obstaculo(obstaculo),
        .acao(acao), .valor_digito(valor_digito), .anodo(anodo),
        .ocupado(ocupado), .fim(fim), .erro(erro)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: 0=idle, 1=running, 2=paused, 3=done
    int m_state, m_acao, m_timer, m_ciclos, m_erro, m_fim, m_cyc, m_nticks;

    function automatic void model_reset();
        m_state = 0; m_acao = 0; m_timer = 0; m_ciclos = 0;
        m_erro = 0; m_fim = 0; m_cyc = 0; m_nticks = 0;
    endfunction

    function automatic void model_step(input bit ini, input bit pau, input bit obs);
        bit t;
        t = ((m_cyc % P) == P - 1);
        m_cyc++;
        if (t) m_nticks++;
        m_fim = 0;
        if (m_state == 0 || m_state == 3) begin
            if (ini && !obs) begin
                m_state = 1; m_acao = 1; m_timer = 0; m_erro = 0;
            end
        end else if (m_state == 1) begin
            if (obs) begin
                m_state = 0; m_acao = 0; m_timer = 0; m_erro = 1;
            end else if (pau) begin
                m_state = 2;
            end else if (t) begin
                m_timer++;
                if (m_timer == D) begin
                    if (m_acao < A) begin
                        m_acao++; m_timer = 0;
                    end else begin
                        m_state = 3; m_fim = 1; m_ciclos = (m_ciclos + 1) % 10;
                    end
                end
            end
        end else begin
            if (obs) begin
                m_state = 0; m_acao = 0; m_timer = 0; m_erro = 1;
            end else if (!pau) begin
                m_state = 1;
            end
        end
    endfunction

    function automatic logic [3:0] model_valor();
        case (m_nticks % 4)
            0: return 4'(m_acao);
            1: return 4'(m_ciclos);
            2: return 4'(m_state);
            default: return 4'hF;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; iniciar = 1'b0; pausar = 1'b0; obstaculo = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    // Start lands on the same edge as a prescaler tick, so each action lasts exactly D*P clocks.
    task automatic start_aligned();
        apply_reset();
        repeat (3) step();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic read_digit(input logic [3:0] an, output logic [3:0] v, output bit ok);
        ok = 0;
        v = 4'h0;
        for (int i = 0; i < 24; i++) begin
            if (anodo === an) begin
                ok = 1;
                v = valor_digito;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (acao !== 4'd0) begin n_err++; $display("FAIL reset_acao got=%h exp=0", acao); end
        n_cmp++; if (valor_digito !== 4'd0) begin n_err++; $display("FAIL reset_valor got=%h exp=0", valor_digito); end
        n_cmp++; if (anodo !== 4'b1110) begin n_err++; $display("FAIL reset_anodo got=%b exp=1110", anodo); end
        n_cmp++; if ({ocupado, fim, erro} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {ocupado, fim, erro}); end
    endtask

    task automatic test_scan();
        logic [3:0] an_tbl [4];
        logic [3:0] va_tbl [4];
        int idx;
        an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        va_tbl = '{4'h0, 4'h0, 4'h0, 4'hF};
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            step();
            idx = (k / 4) % 4;
            n_cmp++;
            if (anodo !== an_tbl[idx] || valor_digito !== va_tbl[idx]) begin
                n_err++;
                $display("FAIL scan k=%0d got anodo=%b valor=%h exp anodo=%b valor=%h",
                         k, anodo, valor_digito, an_tbl[idx], va_tbl[idx]);
            end
        end
    endtask

    task automatic test_full_sequence();
        logic [3:0] v;
        bit ok;
        start_aligned();
        n_cmp++; if (acao !== 4'd1 || ocupado !== 1'b1) begin n_err++; $display("FAIL seq_start got acao=%h ocupado=%b exp 1/1", acao, ocupado); end
        repeat (11) step();
        n_cmp++; if (acao !== 4'd1) begin n_err++; $display("FAIL seq_hold1 got=%h exp=1", acao); end
        step();
        n_cmp++; if (acao !== 4'd2) begin n_err++; $display("FAIL seq_acao2 got=%h exp=2", acao); end
        repeat (11) step();
        n_cmp++; if (acao !== 4'd2) begin n_err++; $display("FAIL seq_hold2 got=%h exp=2", acao); end
        step();
        n_cmp++; if (acao !== 4'd3) begin n_err++; $display("FAIL seq_acao3 got=%h exp=3", acao); end
        repeat (11) step();
        n_cmp++; if (fim !== 1'b0 || ocupado !== 1'b1) begin n_err++; $display("FAIL seq_prefim got fim=%b ocupado=%b exp 0/1", fim, ocupado); end
        step();
        n_cmp++;
        if (fim !== 1'b1 || ocupado !== 1'b0 || acao !== 4'd3) begin
            n_err++;
            $display("FAIL seq_fim got fim=%b ocupado=%b acao=%h exp 1/0/3", fim, ocupado, acao);
        end
        step();
        n_cmp++; if (fim !== 1'b0 || acao !== 4'd3) begin n_err++; $display("FAIL seq_fim_pulse got fim=%b acao=%h exp 0/3", fim, acao); end
        read_digit(4'b1101, v, ok);
        n_cmp++; if (!ok || v !== 4'd1) begin n_err++; $display("FAIL seq_ciclos got=%h found=%0d exp=1", v, ok); end
        read_digit(4'b1011, v, ok);
        n_cmp++; if (!ok || v !== 4'd3) begin n_err++; $display("FAIL seq_state_fim got=%h found=%0d exp=3", v, ok); end
        obstaculo = 1'b1;
        repeat (20) step();
        obstaculo = 1'b0;
        read_digit(4'b1011, v, ok);
        n_cmp++; if (!ok || v !== 4'd3 || erro !== 1'b0) begin n_err++; $display("FAIL fim_obstacle got state=%h erro=%b exp 3/0", v, erro); end
    endtask

    task automatic test_pause();
        logic [3:0] v;
        bit seen2 = 0;
        bit frozen_ok = 1;
        start_aligned();
        repeat (12) step();
        repeat (4) step();
        pausar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acao !== 4'd2 || ocupado !== 1'b1) frozen_ok = 0;
            if (anodo === 4'b1011 && valor_digito === 4'd2) seen2 = 1;
        end
        pausar = 1'b0;
        n_cmp++; if (!frozen_ok) begin n_err++; $display("FAIL pause_frozen got acao=%h exp=2 throughout pause", acao); end
        n_cmp++; if (!seen2) begin n_err++; $display("FAIL pause_state_digit got seen=0 exp state 2 on digit 2"); end
        repeat (7) step();
        n_cmp++; if (acao !== 4'd2) begin n_err++; $display("FAIL pause_resume_hold got=%h exp=2", acao); end
        step();
        n_cmp++; if (acao !== 4'd3) begin n_err++; $display("FAIL pause_resume_adv got=%h exp=3", acao); end
        v = 4'h0;
    endtask

    task automatic test_abort();
        start_aligned();
        repeat (14) step();
        obstaculo = 1'b1;
        step();
        n_cmp++;
        if (acao !== 4'd0 || erro !== 1'b1 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL abort got acao=%h erro=%b ocupado=%b exp 0/1/0", acao, erro, ocupado);
        end
        iniciar = 1'b1;
        repeat (2) step();
        n_cmp++; if (acao !== 4'd0 || erro !== 1'b1) begin n_err++; $display("FAIL abort_blocked got acao=%h erro=%b exp 0/1", acao, erro); end
        obstaculo = 1'b0;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (acao !== 4'd1 || erro !== 1'b0 || ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL abort_restart got acao=%h erro=%b ocupado=%b exp 1/0/1", acao, erro, ocupado);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] v;
        bit ok;
        bit got_fim;
        apply_reset();
        for (int s = 0; s < 10; s++) begin
            iniciar = 1'b1;
            step();
            iniciar = 1'b0;
            got_fim = 0;
            for (int i = 0; i < 60; i++) begin
                step();
                if (fim === 1'b1) begin got_fim = 1; break; end
            end
            n_cmp++; if (!got_fim) begin n_err++; $display("FAIL wrap_fim seq=%0d got no fim exp fim within 60 clks", s); end
            if (s == 8 || s == 9) begin
                read_digit(4'b1101, v, ok);
                n_cmp++;
                if (!ok || v !== ((s == 8) ? 4'd9 : 4'd0)) begin
                    n_err++;
                    $display("FAIL wrap_ciclos seq=%0d got=%h exp=%h", s, v, (s == 8) ? 4'd9 : 4'd0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] v;
        bit ok;
        start_aligned();
        repeat (40) step();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        repeat (15) step();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (acao !== 4'd0 || valor_digito !== 4'd0 || anodo !== 4'b1110 || {ocupado, fim, erro} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset got acao=%h valor=%h anodo=%b flags=%b exp 0/0/1110/000",
                     acao, valor_digito, anodo, {ocupado, fim, erro});
        end
        step();
        reset = 1'b0;
        read_digit(4'b1101, v, ok);
        n_cmp++; if (!ok || v !== 4'd0) begin n_err++; $display("FAIL async_reset_ciclos got=%h exp=0", v); end
    endtask

    task automatic test_random();
        bit p = 0;
        bit ini, obs;
        logic [3:0] exp_an;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            ini = ($urandom_range(0, 19) == 0);
            obs = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 29) == 0) p = ~p;
            iniciar = ini; pausar = p; obstaculo = obs;
            model_step(ini, p, obs);
            step();
            exp_an = ~(4'b0001 << (m_nticks % 4));
            n_cmp++;
            if (acao !== 4'(m_acao) || valor_digito !== model_valor() || anodo !== exp_an ||
                ocupado !== (m_state == 1 || m_state == 2) || fim !== m_fim[0] || erro !== m_erro[0]) begin
                n_err++;
                $display("FAIL random c=%0d got acao=%h valor=%h anodo=%b ocup=%b fim=%b erro=%b exp acao=%h valor=%h anodo=%b ocup=%b fim=%b erro=%b",
                         c, acao, valor_digito, anodo, ocupado, fim, erro,
                         4'(m_acao), model_valor(), exp_an, (m_state == 1 || m_state == 2), m_fim[0], m_erro[0]);
            end
        end
        iniciar = 1'b0; pausar = 1'b0; obstaculo = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_full_sequence();
        test_pause();
        test_abort();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
